ahb_mem_slave: RTL and testbench

//  AHB-lite memory responder: the slave end of one hsel_N line from the address decoder.

---
 rtl/ahb_mem_slave.sv | 199 +++++++++++++++++++
 tb/tb_ahb_mem_slave.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave
//   AHB-lite memory responder sitting behind one hsel line of the address
//   decoder. A selected NONSEQ/SEQ transfer is captured in its address phase,
//   held for WAIT_STATES data-phase cycles and then completed against an
//   internal word memory with an OKAY response. Out-of-range and misaligned
//   accesses, and unsupported sizes, get the two-cycle ERROR response.
//
// Parameters
//   MEM_WORDS    number of 32-bit words (power of 2, <= 4096); index = haddr[13:2]
//   WAIT_STATES  data-phase wait cycles per OKAY transfer (0..7)
//
// Ports
//   hclk       in   1   bus clock, all state on the rising edge
//   hreset     in   1   asynchronous active-high reset
//   hsel       in   1   slave select (address phase)
//   haddr      in   16  byte address; [15:14] decoded upstream, ignored here
//   htrans     in   2   IDLE/BUSY/NONSEQ/SEQ
//   hwrite     in   1   1 = write (address phase)
//   hsize      in   3   byte/halfword/word; anything larger is an error
//   hwdata     in   32  write data (data phase)
//   hready     in   1   bus-level ready from the response mux
//   hreadyout  out  1   this slave's ready
//   hresp      out  1   0 OKAY, 1 ERROR
//   hrdata     out  32  read data, valid in the completion cycle of a read
module ahb_mem_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [15:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int          AW          = $clog2(MEM_WORDS);
  localparam logic [12:0] MEM_WORDS_L = 13'(MEM_WORDS);
  localparam logic [2:0]  WS_LAST     = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam bit          HAS_WAIT    = (WAIT_STATES > 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      cnt_reg;
  logic            pend_reg;     // an OKAY transfer is in its data phase
  logic            write_reg;
  logic [AW-1:0]   idx_reg;
  logic [3:0]      be_reg;
  logic [31:0]     hrdata_reg;

  logic [31:0]     mem [MEM_WORDS];

  logic            can_accept, accept, bad_access, acc_ok, acc_err;
  logic [11:0]     word_idx;
  logic [AW-1:0]   in_idx, rd_idx;
  logic [3:0]      be_in;
  logic            cmpl, mem_we, rd_fire, fwd;
  logic [31:0]     rd_merged;

  logic            unused_ok;
  assign unused_ok = &{1'b0, haddr[15:14], htrans[0]};

  // ---------------------------------------------------------------------------
  // Address phase decode
  // ---------------------------------------------------------------------------
  // Only IDLE and ERR2 drive hreadyout=1, so only those states can see a
  // legal accept; gating here keeps a misbehaving master from corrupting WAIT.
  assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);
  assign accept     = can_accept && hsel && hready && htrans[1];
  assign word_idx   = haddr[13:2];
  assign in_idx     = haddr[AW+1:2];

  always_comb begin
    bad_access = ({1'b0, word_idx} >= MEM_WORDS_L);
    case (hsize)
      3'b000:  ;
      3'b001:  if (haddr[0]) bad_access = 1'b1;
      3'b010:  if (haddr[1:0] != 2'b00) bad_access = 1'b1;
      default: bad_access = 1'b1;
    endcase
  end

  always_comb begin
    case (hsize)
      3'b000:  be_in = 4'b0001 << haddr[1:0];
      3'b001:  be_in = haddr[1] ? 4'b1100 : 4'b0011;
      default: be_in = 4'b1111;
    endcase
  end

  assign acc_ok  = accept && !bad_access;
  assign acc_err = accept &&  bad_access;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_ERR2: begin
        if (acc_err)                 state_next = ST_ERR1;
        else if (acc_ok && HAS_WAIT) state_next = ST_WAIT;
        else                         state_next = ST_IDLE;
      end
      ST_WAIT: if (cnt_reg == 3'd0) state_next = ST_IDLE;
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_reg)
      ST_WAIT: hreadyout = 1'b0;
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  assign hrdata = hrdata_reg;

  // ---------------------------------------------------------------------------
  // Data phase
  // ---------------------------------------------------------------------------
  // The completion cycle is always spent in IDLE with a pending transfer:
  // either right after the last WAIT cycle or, with no wait states, the cycle
  // after the accept.
  assign cmpl   = (state_reg == ST_IDLE) && pend_reg;
  assign mem_we = cmpl && write_reg;

  // The memory is read on the edge that enters the completion cycle so that
  // hrdata is registered and valid there. With no wait states that edge is
  // the accept edge itself.
  assign rd_fire = HAS_WAIT ? ((state_reg == ST_WAIT) && (cnt_reg == 3'd0) && !write_reg)
                            : (acc_ok && !hwrite);
  assign rd_idx  = HAS_WAIT ? idx_reg : in_idx;

  // A write completing on the same edge as a read to the same word must be
  // visible to that read; merge the lanes being written into the read word.
  assign fwd = mem_we && (idx_reg == rd_idx);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_merged[gi*8 +: 8] = (fwd && be_reg[gi]) ? hwdata[gi*8 +: 8]
                                                      : mem[rd_idx][gi*8 +: 8];
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      cnt_reg    <= 3'd0;
      pend_reg   <= 1'b0;
      write_reg  <= 1'b0;
      idx_reg    <= '0;
      be_reg     <= 4'b0000;
      hrdata_reg <= 32'h0;
    end else begin
      if (acc_ok) begin
        // A new accept may land in the completion cycle of the previous one;
        // it simply takes over the pending slot.
        pend_reg  <= 1'b1;
        write_reg <= hwrite;
        idx_reg   <= in_idx;
        be_reg    <= be_in;
        cnt_reg   <= WS_LAST;
      end else begin
        if (cmpl) pend_reg <= 1'b0;
        if ((state_reg == ST_WAIT) && (cnt_reg != 3'd0)) cnt_reg <= cnt_reg - 3'd1;
      end
      if (rd_fire) hrdata_reg <= rd_merged;
    end
  end

  // Memory contents are deliberately not reset. A reset clears pend_reg at
  // once, so an interrupted write can never commit.
  always_ff @(posedge hclk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be_reg[b]) mem[idx_reg][b*8 +: 8] <= hwdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
module tb_ahb_mem_slave;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic [2:0]  hsel_v;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        force_stall;
  int          active;

  logic        hro [3];
  logic        hrs [3];
  logic [31:0] hrd [3];

  always #5 hclk = ~hclk;

  always_comb hready = force_stall ? 1'b0 : hro[active];

  ahb_mem_slave #(.MEM_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hro[0]), .hresp(hrs[0]), .hrdata(hrd[0]));

  ahb_mem_slave #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hro[1]), .hresp(hrs[1]), .hrdata(hrd[1]));

  ahb_mem_slave #(.MEM_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hro[2]), .hresp(hrs[2]), .hrdata(hrd[2]));

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    int          stalls;
    logic [31:0] rdata;
  } xfer_t;

  xfer_t prog[$];   // transfers still to be issued
  xfer_t sb[$];     // expectations of issued, not yet completed transfers
  int    total = 0;
  int    bad   = 0;
  string tname = "reset";

  localparam logic [1:0] NSEQ = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;
  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s/%s: observed=%h expected=%h", tname, tag, obs, expv);
    end
  endtask

  task automatic add(input logic [15:0] a, input logic [1:0] tr, input logic w,
                     input logic [2:0] sz, input logic [31:0] wd, input logic e,
                     input logic [31:0] rd);
    xfer_t x;
    x.addr = a; x.trans = tr; x.write = w; x.size = sz; x.wdata = wd;
    x.err = e; x.stalls = 0; x.rdata = rd;
    prog.push_back(x);
  endtask

  task automatic drive_idle();
    hsel_v = 3'b000; htrans = 2'b00; haddr = 16'h0; hwrite = 1'b0; hsize = 3'b000;
  endtask

  // Pipelined AHB master: address of the next transfer overlaps the data
  // phase of the current one; both advance only when hready is high.
  task automatic run(input int inst, input int ws);
    xfer_t       ex;
    logic [31:0] dp_wdata = 32'h0;
    bit          dp_v = 1'b0;
    bit          head_pushed = 1'b0;
    int          stalls = 0;
    int          guard = 0;
    logic        rdy;
    active = inst;
    while ((prog.size() > 0 || dp_v) && guard < 200) begin
      guard++;
      if (prog.size() > 0) begin
        hsel_v = 3'(1 << inst);
        haddr  = prog[0].addr;
        htrans = prog[0].trans;
        hwrite = prog[0].write;
        hsize  = prog[0].size;
        if (!head_pushed) begin
          ex = prog[0];
          ex.stalls = prog[0].err ? 1 : ws;
          sb.push_back(ex);
          head_pushed = 1'b1;
        end
      end else begin
        drive_idle();
      end
      hwdata = dp_v ? dp_wdata : 32'h0;
      @(negedge hclk);
      rdy = hready;
      if (dp_v) begin
        if (!rdy) begin
          stalls++;
          check("stall_hresp", {31'h0, hrs[inst]}, {31'h0, sb[0].err});
        end else begin
          ex = sb.pop_front();
          $display("[%s] %s addr=%h size=%0d resp=%0d stalls=%0d rdata=%h", tname,
                   ex.write ? "WR" : "RD", ex.addr, ex.size, hrs[inst], stalls, hrd[inst]);
          check("hresp", {31'h0, hrs[inst]}, {31'h0, ex.err});
          check("stalls", stalls, ex.stalls);
          if (!ex.write && !ex.err) check("rdata", hrd[inst], ex.rdata);
          stalls = 0;
          dp_v   = 1'b0;
        end
      end
      @(posedge hclk); #1;
      if (rdy && prog.size() > 0) begin
        dp_wdata = prog[0].wdata;
        void'(prog.pop_front());
        dp_v = 1'b1;
        head_pushed = 1'b0;
      end
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("FAIL %s/timeout: transfers left=%0d required=0", tname, prog.size() + sb.size());
      prog.delete();
      sb.delete();
    end
    drive_idle();
    hwdata = 32'h0;
  endtask

  task automatic idle_check(input int inst, input string tag);
    @(negedge hclk);
    check({tag, "_rdy"},  {31'h0, hro[inst]}, 32'h1);
    check({tag, "_resp"}, {31'h0, hrs[inst]}, 32'h0);
    @(posedge hclk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    hwdata = 32'h0;
    force_stall = 1'b0;
    active = 0;

    // Reset values on every instance
    @(negedge hclk);
    for (int i = 0; i < 3; i++) begin
      check("rst_rdy",   {31'h0, hro[i]}, 32'h1);
      check("rst_resp",  {31'h0, hrs[i]}, 32'h0);
      check("rst_rdata", hrd[i], 32'h0);
    end
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;

    // T1: word write then read, one wait state each
    tname = "t1";
    add(16'h0010, NSEQ, 1'b1, SZ_W, 32'hDEADBEEF, 1'b0, 32'h0);
    add(16'h0010, NSEQ, 1'b0, SZ_W, 32'h0,        1'b0, 32'hDEADBEEF);
    run(0, 1);

    // T2: byte write on lane 3 over a known word
    tname = "t2";
    add(16'h0010, NSEQ, 1'b1, SZ_W, 32'h11223344, 1'b0, 32'h0);
    add(16'h0013, NSEQ, 1'b1, SZ_B, 32'hAA556677, 1'b0, 32'h0);
    add(16'h0010, NSEQ, 1'b0, SZ_W, 32'h0,        1'b0, 32'hAA223344);
    run(0, 1);

    // T3: out-of-range and bad-size/alignment errors; memory untouched
    tname = "t3";
    add(16'h0000, NSEQ, 1'b1, SZ_W,   32'h600DCAFE, 1'b0, 32'h0);
    add(16'h1000, NSEQ, 1'b0, SZ_W,   32'h0,        1'b1, 32'h0);
    add(16'h1000, NSEQ, 1'b1, SZ_W,   32'hBAD0BAD0, 1'b1, 32'h0);
    add(16'h0002, NSEQ, 1'b1, SZ_W,   32'hBAD1BAD1, 1'b1, 32'h0);
    add(16'h0000, NSEQ, 1'b1, 3'b011, 32'hBAD2BAD2, 1'b1, 32'h0);
    add(16'h0000, NSEQ, 1'b0, SZ_W,   32'h0,        1'b0, 32'h600DCAFE);
    run(0, 1);
    idle_check(0, "t3_idle");

    // T4: misaligned halfword errors, aligned upper halfword works
    tname = "t4";
    add(16'h0020, NSEQ, 1'b1, SZ_W, 32'hCAFEF00D, 1'b0, 32'h0);
    add(16'h0021, NSEQ, 1'b1, SZ_H, 32'h12345678, 1'b1, 32'h0);
    add(16'h0020, NSEQ, 1'b0, SZ_W, 32'h0,        1'b0, 32'hCAFEF00D);
    add(16'h0022, NSEQ, 1'b1, SZ_H, 32'hBEEF1234, 1'b0, 32'h0);
    add(16'h0020, NSEQ, 1'b0, SZ_W, 32'h0,        1'b0, 32'hBEEFF00D);
    run(0, 1);

    // hready low while idle: nothing may be captured
    tname = "stall";
    add(16'h0030, NSEQ, 1'b1, SZ_W, 32'h31313131, 1'b0, 32'h0);
    run(0, 1);
    active = 0;
    force_stall = 1'b1;
    hsel_v = 3'b001; haddr = 16'h0030; htrans = NSEQ; hwrite = 1'b1; hsize = SZ_W;
    @(posedge hclk); #1;
    force_stall = 1'b0;
    drive_idle();
    hwdata = 32'hFFFFFFFF;
    idle_check(0, "stall_idle1");
    idle_check(0, "stall_idle2");
    hwdata = 32'h0;
    add(16'h0030, NSEQ, 1'b0, SZ_W, 32'h0, 1'b0, 32'h31313131);
    run(0, 1);

    // T5: zero wait states, back-to-back, including same-word read after write
    tname = "t5";
    add(16'h0000, NSEQ, 1'b1, SZ_W, 32'h01234567, 1'b0, 32'h0);
    add(16'h0004, SEQ,  1'b1, SZ_W, 32'h89ABCDEF, 1'b0, 32'h0);
    add(16'h0000, NSEQ, 1'b0, SZ_W, 32'h0,        1'b0, 32'h01234567);
    add(16'h0004, SEQ,  1'b0, SZ_W, 32'h0,        1'b0, 32'h89ABCDEF);
    add(16'h0008, NSEQ, 1'b1, SZ_W, 32'h0BADF00D, 1'b0, 32'h0);
    add(16'h0008, NSEQ, 1'b0, SZ_W, 32'h0,        1'b0, 32'h0BADF00D);
    add(16'h0009, NSEQ, 1'b1, SZ_B, 32'h1122EE44, 1'b0, 32'h0);
    add(16'h0008, NSEQ, 1'b0, SZ_W, 32'h0,        1'b0, 32'h0BADEE0D);
    run(1, 0);

    // T6: reset during the wait states of a write
    tname = "t6";
    add(16'h0040, NSEQ, 1'b1, SZ_W, 32'h5555AAAA, 1'b0, 32'h0);
    add(16'h0040, NSEQ, 1'b0, SZ_W, 32'h0,        1'b0, 32'h5555AAAA);
    run(2, 3);
    active = 2;
    hsel_v = 3'b100; haddr = 16'h0040; htrans = NSEQ; hwrite = 1'b1; hsize = SZ_W;
    @(posedge hclk); #1;
    drive_idle();
    hwdata = 32'h12345678;
    @(negedge hclk);
    check("in_wait_rdy", {31'h0, hro[2]}, 32'h0);
    #1 hreset = 1'b1;
    #1;
    check("rst_rdy",   {31'h0, hro[2]}, 32'h1);
    check("rst_resp",  {31'h0, hrs[2]}, 32'h0);
    check("rst_rdata", hrd[2], 32'h0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    repeat (4) @(posedge hclk);
    #1;
    hwdata = 32'h0;
    add(16'h0040, NSEQ, 1'b0, SZ_W, 32'h0, 1'b0, 32'h5555AAAA);
    run(2, 3);
    idle_check(2, "t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
